// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the four-channel frame write scheduler.
package frame_sched_pkg;

  localparam int CH_NUM = 4;

  localparam logic [31:0] BANK_A_BASE = 32'h0000_0000;
  localparam logic [31:0] BANK_B_BASE = 32'h0010_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } frame_state_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Quadrant origin of each channel inside the 2x2 mosaic frame buffer.
  function automatic logic [31:0] ch_offset(input int ch, input int col, input int row);
    case (ch)
      0:       return 32'd0;
      1:       return 32'(col / 4);
      2:       return 32'(col * row / 4);
      default: return 32'(col * row / 4 + col / 4);
    endcase
  endfunction

endpackage

// File: rtl/frame_write_sched_if.sv
// Shared AXI write-burst port between the scheduler and the AXI master.
interface frame_write_sched_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
);
  logic              wr_burst_req;
  logic [7:0]        wr_burst_len;
  logic [ADDR_W-1:0] wr_burst_addr;
  logic              wr_burst_data_req;
  logic [DATA_W-1:0] wr_burst_data;
  logic              wr_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish
  );
endinterface

// File: rtl/burst_rr_arbiter.sv
// Round-robin burst arbiter: grants one channel, locks it until the AXI
// master finishes the burst, and routes data/handshake for that channel.
module burst_rr_arbiter
  import frame_sched_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
) (
  input  logic                     axi_aclk,
  input  logic                     axi_rst,
  input  logic [CH_NUM-1:0]        ch_burst_req,
  input  logic [CH_NUM*8-1:0]      ch_burst_len,
  input  logic [CH_NUM*ADDR_W-1:0] ch_burst_addr,
  input  logic [CH_NUM*DATA_W-1:0] ch_burst_data,
  output logic [CH_NUM-1:0]        ch_burst_data_req,
  output logic [CH_NUM-1:0]        ch_burst_finish,
  frame_write_sched_if.master      wr
);

  arb_state_e state;
  logic [1:0] ptr;
  logic [1:0] gnt;
  logic [1:0] sel;
  logic [1:0] idx;
  logic       found;
  logic       busy;

  // First requester at or after ptr, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    idx   = ptr;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = ptr + 2'(i);
      if (!found && ch_burst_req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      state            <= ARB_IDLE;
      ptr              <= 2'd0;
      gnt              <= 2'd0;
      wr.wr_burst_req  <= 1'b0;
      wr.wr_burst_len  <= 8'd0;
      wr.wr_burst_addr <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state            <= ARB_BUSY;
            gnt              <= sel;
            wr.wr_burst_req  <= 1'b1;
            wr.wr_burst_len  <= ch_burst_len[sel*8 +: 8];
            wr.wr_burst_addr <= ch_burst_addr[sel*ADDR_W +: ADDR_W];
          end
        end
        ARB_BUSY: begin
          if (wr.wr_burst_finish) begin
            state           <= ARB_IDLE;
            wr.wr_burst_req <= 1'b0;
            ptr             <= gnt + 2'd1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // FIFO read data follows rd_en directly, so the data mux must add no latency.
  assign busy              = (state == ARB_BUSY);
  assign wr.wr_burst_data  = busy ? ch_burst_data[gnt*DATA_W +: DATA_W] : '0;
  assign ch_burst_data_req = busy ? (CH_NUM'(wr.wr_burst_data_req) << gnt) : '0;
  assign ch_burst_finish   = busy ? (CH_NUM'(wr.wr_burst_finish) << gnt) : '0;

endmodule

// File: rtl/frame_write_sched.sv
// Four-channel frame write scheduler: per-channel A/B bank ping-pong frame
// FSMs plus a shared round-robin AXI write-burst port.
module frame_write_sched
  import frame_sched_pkg::*;
#(
  parameter int                IMG_COL = 1280,
  parameter int                IMG_ROW = 720,
  parameter int                ADDR_W  = 28,
  parameter int                DATA_W  = 256,
  parameter logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BANK_A_BASE),
  parameter logic [ADDR_W-1:0] BASE_B  = ADDR_W'(BANK_B_BASE)
) (
  input  logic                     axi_aclk,
  input  logic                     axi_rst,
  input  logic [CH_NUM-1:0]        ch_frame_start,
  output logic [CH_NUM-1:0]        ch_write_req,
  output logic [CH_NUM*ADDR_W-1:0] ch_write_addr,
  input  logic [CH_NUM-1:0]        ch_write_done,
  input  logic [CH_NUM-1:0]        ch_burst_req,
  input  logic [CH_NUM*8-1:0]      ch_burst_len,
  input  logic [CH_NUM*ADDR_W-1:0] ch_burst_addr,
  input  logic [CH_NUM*DATA_W-1:0] ch_burst_data,
  output logic [CH_NUM-1:0]        ch_burst_data_req,
  output logic [CH_NUM-1:0]        ch_burst_finish,
  frame_write_sched_if.master      wr,
  output logic [CH_NUM-1:0]        rd_bank,
  output logic [CH_NUM-1:0]        ch_overrun
);

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    localparam logic [ADDR_W-1:0] OFF = ADDR_W'(ch_offset(n, IMG_COL, IMG_ROW));

    frame_state_e      st;
    logic              wr_bank;
    logic              rd_b;
    logic              req_r;
    logic              ov_r;
    logic              gap_cnt;
    logic [ADDR_W-1:0] addr_r;

    always_ff @(posedge axi_aclk or posedge axi_rst) begin
      if (axi_rst) begin
        st      <= IDLE;
        wr_bank <= 1'b0;
        rd_b    <= 1'b0;
        req_r   <= 1'b0;
        ov_r    <= 1'b0;
        gap_cnt <= 1'b0;
        addr_r  <= '0;
      end else begin
        if (ch_frame_start[n] && st != IDLE)
          ov_r <= 1'b1;
        case (st)
          IDLE: begin
            if (ch_frame_start[n]) begin
              st     <= ACTIVE;
              req_r  <= 1'b1;
              addr_r <= (wr_bank ? BASE_B : BASE_A) + OFF;
            end
          end
          ACTIVE: begin
            if (ch_write_done[n]) begin
              rd_b    <= wr_bank;
              wr_bank <= ~wr_bank;
              req_r   <= 1'b0;
              gap_cnt <= 1'b0;
              st      <= GAP;
            end
          end
          // Two low cycles so the frame writer always sees a fresh rising edge.
          GAP: begin
            gap_cnt <= 1'b1;
            if (gap_cnt)
              st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign ch_write_req[n]                  = req_r;
    assign ch_write_addr[n*ADDR_W +: ADDR_W] = addr_r;
    assign rd_bank[n]                       = rd_b;
    assign ch_overrun[n]                    = ov_r;
  end

  burst_rr_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_arb (
    .axi_aclk          (axi_aclk),
    .axi_rst           (axi_rst),
    .ch_burst_req      (ch_burst_req),
    .ch_burst_len      (ch_burst_len),
    .ch_burst_addr     (ch_burst_addr),
    .ch_burst_data     (ch_burst_data),
    .ch_burst_data_req (ch_burst_data_req),
    .ch_burst_finish   (ch_burst_finish),
    .wr                (wr)
  );

endmodule

// File: tb/tb_frame_write_sched.sv
// Self-checking bench for frame_write_sched: frame FSM vector table, burst
// corner sequences, and randomized bursts against a round-robin model.
module tb_frame_write_sched;
  import frame_sched_pkg::*;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;

  logic                     axi_aclk = 1'b0;
  logic                     axi_rst;
  logic [3:0]               ch_frame_start;
  logic [3:0]               ch_write_req;
  logic [4*ADDR_W-1:0]      ch_write_addr;
  logic [3:0]               ch_write_done;
  logic [3:0]               ch_burst_req;
  logic [4*8-1:0]           ch_burst_len;
  logic [4*ADDR_W-1:0]      ch_burst_addr;
  logic [4*DATA_W-1:0]      ch_burst_data;
  logic [3:0]               ch_burst_data_req;
  logic [3:0]               ch_burst_finish;
  logic [3:0]               rd_bank;
  logic [3:0]               ch_overrun;

  frame_write_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

  frame_write_sched #(
    .IMG_COL(1280), .IMG_ROW(720), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BASE_A(28'h000_0000), .BASE_B(28'h010_0000)
  ) dut (
    .axi_aclk          (axi_aclk),
    .axi_rst           (axi_rst),
    .ch_frame_start    (ch_frame_start),
    .ch_write_req      (ch_write_req),
    .ch_write_addr     (ch_write_addr),
    .ch_write_done     (ch_write_done),
    .ch_burst_req      (ch_burst_req),
    .ch_burst_len      (ch_burst_len),
    .ch_burst_addr     (ch_burst_addr),
    .ch_burst_data     (ch_burst_data),
    .ch_burst_data_req (ch_burst_data_req),
    .ch_burst_finish   (ch_burst_finish),
    .wr                (wr_if),
    .rd_bank           (rd_bank),
    .ch_overrun        (ch_overrun)
  );

  always #5 axi_aclk = ~axi_aclk;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] waddr(input int c);
    return ch_write_addr[c*ADDR_W +: ADDR_W];
  endfunction

  // Reference: next grant is the first requester after the last granted channel.
  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Counts write_req rising edges per channel.
  logic [3:0] req_q = 4'b0;
  int rise[4] = '{0, 0, 0, 0};
  always @(posedge axi_aclk) begin
    for (int i = 0; i < 4; i++)
      if (ch_write_req[i] && !req_q[i]) rise[i]++;
    req_q <= ch_write_req;
  end

  typedef struct {
    logic [3:0]        start;
    logic [3:0]        done;
    logic [3:0]        exp_req;
    logic [3:0]        exp_rd;
    logic [3:0]        exp_ov;
    int                ch;
    logic [ADDR_W-1:0] exp_addr;
  } fvec_t;

  fvec_t fv[16];

  logic [7:0]        blen[4];
  logic [ADDR_W-1:0] baddr[4];

  task automatic load_burst_params();
    for (int c = 0; c < 4; c++) begin
      ch_burst_len[c*8 +: 8]            = blen[c];
      ch_burst_addr[c*ADDR_W +: ADDR_W] = baddr[c];
    end
  endtask

  task automatic rand_data();
    for (int w = 0; w < 4*DATA_W/32; w++) ch_burst_data[w*32 +: 32] = $urandom();
  endtask

  task automatic check_grant(input string nm, input int g);
    chk({nm, "_req"}, 256'(wr_if.wr_burst_req), 256'(1));
    chk({nm, "_len"}, 256'(wr_if.wr_burst_len), 256'(blen[g]));
    chk({nm, "_addr"}, 256'(wr_if.wr_burst_addr), 256'(baddr[g]));
  endtask

  task automatic finish_burst(input string nm, input int g);
    wr_if.wr_burst_finish = 1'b1;
    #1;
    chk({nm, "_fin_route"}, 256'(ch_burst_finish), 256'(4'b0001 << g));
    step();
    wr_if.wr_burst_finish   = 1'b0;
    wr_if.wr_burst_data_req = 1'b0;
    chk({nm, "_req_low"}, 256'(wr_if.wr_burst_req), 256'(0));
  endtask

  initial begin
    int last;
    logic [3:0] pending;
    int g;
    int nd;

    fv[0]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 28'h000_0140};
    fv[1]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 28'h000_0140};
    fv[2]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 28'h000_0140};
    fv[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 28'h000_0140};
    fv[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 28'h000_0140};
    fv[5]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 28'h010_0140};
    fv[6]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 28'h010_0140};
    fv[7]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 2, 28'h003_8400};
    fv[8]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0010, 4'b0100, 2, 28'h003_8400};
    fv[9]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0100, 2, 28'h003_8400};
    fv[10] = '{4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 2, 28'h003_8400};
    fv[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 2, 28'h003_8400};
    fv[12] = '{4'b0100, 4'b0000, 4'b0100, 4'b0010, 4'b0100, 2, 28'h013_8400};
    fv[13] = '{4'b0000, 4'b0100, 4'b0000, 4'b0110, 4'b0100, 2, 28'h013_8400};
    fv[14] = '{4'b1001, 4'b0000, 4'b1001, 4'b0110, 4'b0100, 3, 28'h003_8540};
    fv[15] = '{4'b0000, 4'b1001, 4'b0000, 4'b0110, 4'b0100, 0, 28'h000_0000};

    for (int c = 0; c < 4; c++) begin
      blen[c]  = 8'h10 + 8'(c);
      baddr[c] = 28'h0A0_0000 + 28'(c * 28'h1000);
    end

    axi_rst                 = 1'b1;
    ch_frame_start          = '0;
    ch_write_done           = '0;
    ch_burst_req            = '0;
    ch_burst_data           = '0;
    wr_if.wr_burst_data_req = 1'b0;
    wr_if.wr_burst_finish   = 1'b0;
    load_burst_params();
    step();
    step();
    chk("rst_write_req", 256'(ch_write_req), 256'(0));
    chk("rst_write_addr", 256'(ch_write_addr), 256'(0));
    chk("rst_rd_bank", 256'(rd_bank), 256'(0));
    chk("rst_overrun", 256'(ch_overrun), 256'(0));
    chk("rst_wr_burst_req", 256'(wr_if.wr_burst_req), 256'(0));
    axi_rst = 1'b0;
    step();

    // Frame FSM vectors: single channel ping-pong, overrun, quadrant offsets.
    for (int i = 0; i < 16; i++) begin
      ch_frame_start = fv[i].start;
      ch_write_done  = fv[i].done;
      step();
      ch_frame_start = '0;
      ch_write_done  = '0;
      chk($sformatf("fv%0d_req", i), 256'(ch_write_req), 256'(fv[i].exp_req));
      chk($sformatf("fv%0d_rd_bank", i), 256'(rd_bank), 256'(fv[i].exp_rd));
      chk($sformatf("fv%0d_overrun", i), 256'(ch_overrun), 256'(fv[i].exp_ov));
      chk($sformatf("fv%0d_addr_ch%0d", i, fv[i].ch), 256'(waddr(fv[i].ch)), 256'(fv[i].exp_addr));
    end
    step();
    chk("rise_ch1", 256'(rise[1]), 256'(2));
    chk("rise_ch2", 256'(rise[2]), 256'(2));
    chk("rise_ch3", 256'(rise[3]), 256'(1));

    // Round-robin with all four channels requesting, finish 20 cycles after grant.
    ch_burst_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      check_grant($sformatf("rr%0d", k), k % 4);
      repeat (19) step();
      finish_burst($sformatf("rr%0d", k), k % 4);
    end

    // Data routing: only ch3 requests (ptr now at 1).
    ch_burst_req = 4'b1000;
    step();
    check_grant("route", 3);
    for (int i = 0; i < 16; i++) begin
      wr_if.wr_burst_data_req = i[0];
      rand_data();
      #1;
      chk($sformatf("route%0d_dreq", i), 256'(ch_burst_data_req), 256'(i[0] ? 4'b1000 : 4'b0000));
      chk($sformatf("route%0d_data", i), wr_if.wr_burst_data, ch_burst_data[3*DATA_W +: DATA_W]);
      step();
    end

    // Reset mid-burst: outputs drop before any clock edge.
    wr_if.wr_burst_data_req = 1'b1;
    #1;
    axi_rst = 1'b1;
    #1;
    chk("mid_rst_req", 256'(wr_if.wr_burst_req), 256'(0));
    chk("mid_rst_len", 256'(wr_if.wr_burst_len), 256'(0));
    chk("mid_rst_addr", 256'(wr_if.wr_burst_addr), 256'(0));
    chk("mid_rst_data", wr_if.wr_burst_data, 256'(0));
    chk("mid_rst_dreq", 256'(ch_burst_data_req), 256'(0));
    chk("mid_rst_rd_bank", 256'(rd_bank), 256'(0));
    chk("mid_rst_overrun", 256'(ch_overrun), 256'(0));
    chk("mid_rst_write_addr", 256'(ch_write_addr), 256'(0));
    wr_if.wr_burst_data_req = 1'b0;
    step();
    axi_rst = 1'b0;
    ch_burst_req = 4'hF;
    step();
    check_grant("post_rst", 0);
    finish_burst("post_rst", 0);
    ch_burst_req   = 4'h0;
    ch_frame_start = 4'b0010;
    step();
    ch_frame_start = '0;
    chk("post_rst_bankA", 256'(waddr(1)), 256'(28'h000_0140));

    // Randomized bursts against the round-robin reference.
    last    = 0;
    pending = '0;
    for (int it = 0; it < 40; it++) begin
      pending |= 4'($urandom_range(0, 15));
      if (pending == 4'b0) pending = 4'b0001 << $urandom_range(0, 3);
      for (int c = 0; c < 4; c++) begin
        blen[c]  = 8'($urandom());
        baddr[c] = 28'($urandom());
      end
      load_burst_params();
      ch_burst_req = pending;
      g = rr_pick(pending, last);
      step();
      check_grant($sformatf("rnd%0d", it), g);
      nd = $urandom_range(1, 8);
      for (int d = 0; d < nd; d++) begin
        wr_if.wr_burst_data_req = 1'($urandom_range(0, 1));
        rand_data();
        #1;
        chk($sformatf("rnd%0d_dreq", it), 256'(ch_burst_data_req),
            256'(wr_if.wr_burst_data_req ? (4'b0001 << g) : 4'b0000));
        chk($sformatf("rnd%0d_data", it), wr_if.wr_burst_data, ch_burst_data[g*DATA_W +: DATA_W]);
        step();
      end
      finish_burst($sformatf("rnd%0d", it), g);
      pending[g] = 1'b0;
      last       = g;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/frame_write_sched.md
# frame_write_sched

Schedules the four `Frame_write` channels of the 2×2 video mosaic onto one shared DDR AXI write-burst port, in the `axi_aclk` domain.
- Frame level: starts each channel's frame with `write_req`/`write_addr` and ping-pongs each channel between buffer banks A and B.
- Burst level: arbitrates the four channels' burst requests round-robin and muxes the granted channel's `wr_burst_*` signals onto the AXI master.
- Publishes, per channel, which bank holds the last complete frame, for the frame reader.

## Interface
Parameters:
- `IMG_COL`, 1280, input video columns.
- `IMG_ROW`, 720, input video rows.
- `ADDR_W`, 28, DDR burst address width.
- `DATA_W`, 256, burst data width.
- `BASE_A`, 28'h000_0000, bank A base.
- `BASE_B`, 28'h010_0000, bank B base.

Ports:
- `axi_aclk` in 1: the only clock.
- `axi_rst` in 1: reset, asynchronous, active-high.
- `ch_frame_start` in 4: per-channel one-cycle pulse, frame start, already synchronized to `axi_aclk`.
- `ch_write_req` out 4: per-channel frame-write command.
- `ch_write_addr` out 4×ADDR_W: per-channel frame base address; channel n occupies bits [n*ADDR_W +: ADDR_W].
- `ch_write_done` in 4: per-channel one-cycle frame-complete pulse.
- `ch_burst_req` in 4: per-channel burst request.
- `ch_burst_len` in 4×8: per-channel burst length.
- `ch_burst_addr` in 4×ADDR_W: per-channel burst address.
- `ch_burst_data` in 4×DATA_W: per-channel burst data.
- `ch_burst_data_req` out 4: per-channel data pop.
- `ch_burst_finish` out 4: per-channel burst-finish pulse.
- `wr_burst_req` out 1: shared-port burst request.
- `wr_burst_len` out 8: shared-port burst length.
- `wr_burst_addr` out ADDR_W: shared-port burst address.
- `wr_burst_data_req` in 1: data pop from the AXI master.
- `wr_burst_data` out DATA_W: shared-port burst data.
- `wr_burst_finish` in 1: burst-finish pulse from the AXI master.
- `rd_bank` out 4: per channel, bank of the last completed frame; 0 = A, 1 = B.
- `ch_overrun` out 4: sticky per-channel flag; a frame start arrived while that channel was not IDLE.

## Operation
Per-channel frame FSM (four instances):
- Channel address offsets: ch0 +0; ch1 +IMG_COL/4; ch2 +IMG_COL*IMG_ROW/4; ch3 +IMG_COL*IMG_ROW/4 + IMG_COL/4.
- IDLE → ACTIVE on `ch_frame_start`.
  - Latches `ch_write_addr` = (wr_bank ? BASE_B : BASE_A) + channel offset.
  - `ch_write_req` goes high.
- ACTIVE: holds `ch_write_req` high and `ch_write_addr` stable.
  - On `ch_write_done`: rd_bank[n] ← wr_bank, wr_bank ← ~wr_bank, `ch_write_req` ← 0, go to GAP.
- GAP: 2 cycles with `ch_write_req` low, which guarantees a detectable rising edge for the next frame; then IDLE.
- `ch_frame_start` in ACTIVE or GAP is ignored and sets `ch_overrun[n]`, which clears only on reset.
- `ch_frame_start` together with `ch_write_done` in ACTIVE: the done is taken; the start counts as an overrun.

Burst arbiter:
- States ARB_IDLE and ARB_BUSY; 2-bit pointer `ptr`, reset 0.
- ARB_IDLE: search `ch_burst_req` starting at `ptr`, wrapping 3→0; the first set bit wins as grant `g`.
  - If found: register `wr_burst_req`=1, `wr_burst_len`=ch len[g], `wr_burst_addr`=ch addr[g]; go to ARB_BUSY.
- ARB_BUSY: grant is locked.
  - `wr_burst_data` = `ch_burst_data[g]`, combinational mux with no added latency, because the FIFO read data follows `rd_en` directly.
  - `ch_burst_data_req[g]` = `wr_burst_data_req`; all other channels read 0.
  - `ch_burst_finish[g]` = `wr_burst_finish`, combinational.
  - On `wr_burst_finish`: `wr_burst_req` ← 0, `ptr` ← g+1 (mod 4), go to ARB_IDLE.
- A channel may drop `ch_burst_req` only after its finish; a drop while granted is not supported.

## Timing
- Reset values: every output 0; wr_bank = 0; both FSMs idle.
- Frame start to `ch_write_req` high: 1 cycle (registered).
- `ch_write_done` to `rd_bank` update: 1 cycle.
- Burst request to `wr_burst_req`: 1 cycle from ARB_IDLE.
- Burst finish to next arbitration:
  - Finish edge to `wr_burst_req` low: 1 cycle.
  - Next grant is decided in the following ARB_IDLE cycle.
  - Minimum idle gap between bursts: 1 cycle.
- Fairness: with all four channels requesting continuously, grants follow 0,1,2,3,0…
- Reset asserted mid-burst: outputs drop asynchronously; the arbiter makes no attempt to complete the AXI transaction.

## Structure
- Shared package `frame_sched_pkg`:
  - `CH_NUM`=4.
  - Bank base constants and the channel-offset function.
  - Frame FSM enum: IDLE/ACTIVE/GAP.
  - Arbiter enum: ARB_IDLE/ARB_BUSY.
- Sub-module `burst_rr_arbiter`: round-robin grant plus lock. The frame FSMs stay in the top level as a generate loop.

## Test plan
- Single channel:
  - Stimulus: ch1 start; done; start; done.
  - Required: `ch_write_addr[1]` = 0x0000140, then 0x0100140; `rd_bank[1]` = 0, then 1.
- Overrun:
  - Stimulus: ch2 start while ACTIVE.
  - Required: `ch_overrun[2]`=1; address unchanged; exactly one `write_req` rising edge.
- Round-robin:
  - Stimulus: all four `ch_burst_req` high; each burst finishes 20 cycles after grant.
  - Required: grant order 0,1,2,3,0; `wr_burst_addr`/`wr_burst_len` match the granted channel.
- Data routing:
  - Stimulus: ch3 granted, 16 `wr_burst_data_req` cycles.
  - Required: only `ch_burst_data_req[3]` toggles; `wr_burst_data` equals `ch_burst_data[3]` in the same cycle.
- Reset mid-burst:
  - Stimulus: assert `axi_rst` during ARB_BUSY.
  - Required: all outputs 0 immediately; after release, `ptr`=0 and wr_bank=A.
